// File: rtl/mod_exp_engine.sv
// Sequential modular exponentiator: result = base^exponent mod modulus, square-and-multiply over interleaved modular multiplies.
// Latency 2 + (EXP_WIDTH + popcount(exponent))*WIDTH cycles; MOD_EXP_EARLY_EXIT_EN starts at the exponent's top set bit.
// Backpressure: start is accepted only while ready=1; result/error hold after done until the next accepted start.
module mod_exp_engine #(
    parameter int WIDTH     = 128,
    parameter int EXP_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     result
);

    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_TOP  = IW'(EXP_WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SQR, S_MUL, S_DONE} state_t;

    state_t               state;
    logic [WIDTH-1:0]     base_q;
    logic [WIDTH-1:0]     mod_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [IW-1:0]        idx;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     prod;

    logic [WIDTH-1:0]     prod_next;
    logic [WIDTH-1:0]     acc_init;
    logic                 operands_bad;
    logic [WIDTH:0]       dbl;
    logic [WIDTH:0]       dbl_red;
    logic [WIDTH:0]       sum;

    // One MSB-first step of the interleaved multiply; both partials stay below 2*modulus.
    always_comb begin
        dbl       = {prod, 1'b0};
        dbl_red   = (dbl >= {1'b0, mod_q}) ? dbl - {1'b0, mod_q} : dbl;
        sum       = mplier[WIDTH-1] ? dbl_red + {1'b0, mcand} : dbl_red;
        prod_next = WIDTH'((sum >= {1'b0, mod_q}) ? sum - {1'b0, mod_q} : sum);
    end

    assign operands_bad = (mod_q == '0) || (base_q >= mod_q);
    assign acc_init     = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);

`ifdef MOD_EXP_EARLY_EXIT_EN
    logic [IW-1:0] msb_idx;

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < EXP_WIDTH; i++) begin
            if (exp_q[i]) msb_idx = IW'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            result <= '0;
            base_q <= '0;
            mod_q  <= '0;
            exp_q  <= '0;
            idx    <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exponent;
                        mod_q  <= modulus;
                        error  <= 1'b0;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    prod   <= '0;
                    cnt    <= '0;
                    mplier <= acc_init;
                    mcand  <= acc_init;
                    if (operands_bad) begin
                        error  <= 1'b1;
                        result <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
`ifdef MOD_EXP_EARLY_EXIT_EN
                    end else if (exp_q == '0) begin
                        result <= acc_init;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx   <= msb_idx;
                        state <= S_SQR;
                    end
`else
                    end else begin
                        idx   <= IDX_TOP;
                        state <= S_SQR;
                    end
`endif
                end
                S_SQR, S_MUL: begin
                    prod   <= prod_next;
                    mplier <= mplier << 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // The finished product becomes the multiplier of whatever runs next.
                        prod   <= '0;
                        cnt    <= '0;
                        mplier <= prod_next;
                        if (state == S_SQR && exp_q[idx]) begin
                            mcand <= base_q;
                            state <= S_MUL;
                        end else if (idx == '0) begin
                            result <= prod_next;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            idx   <= idx - 1'b1;
                            mcand <= prod_next;
                            state <= S_SQR;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed-vector bench for mod_exp_engine at WIDTH=EXP_WIDTH=16, plus handshake, reset and chained RSA sequences.
module tb_mod_exp_engine;

    localparam int W     = 16;
    localparam int LIMIT = 3000;

    typedef struct {
        logic [W-1:0] b;
        logic [W-1:0] e;
        logic [W-1:0] m;
        logic [W-1:0] res;
        logic         err;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] base_d;
    logic [W-1:0] exp_d;
    logic [W-1:0] mod_d;
    logic         ready;
    logic         busy;
    logic         done;
    logic         error;
    logic [W-1:0] result;

    logic         chain_en;
    logic         start2;
    logic [W-1:0] exp2;
    logic [W-1:0] mod2;
    logic         ready2;
    logic         busy2;
    logic         done2;
    logic         error2;
    logic [W-1:0] result2;

    int checks = 0;
    int passes = 0;
    int last_lat;

    assign start2 = done & chain_en;
    assign exp2   = 16'd2753;
    assign mod2   = 16'd3233;

    mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base(base_d), .exponent(exp_d), .modulus(mod_d),
        .ready(ready), .busy(busy), .done(done), .error(error), .result(result)
    );

    mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(W)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .base(result), .exponent(exp2), .modulus(mod2),
        .ready(ready2), .busy(busy2), .done(done2), .error(error2), .result(result2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
        int pop;
        int msb;
        pop = 0;
        msb = -1;
        for (int i = 0; i < W; i++) begin
            if (e[i]) begin
                pop++;
                msb = i;
            end
        end
        if (m == '0 || b >= m) return 2;
`ifdef MOD_EXP_EARLY_EXIT_EN
        if (e == '0) return 2;
        return 2 + (msb + 1 + pop) * W;
`else
        return 2 + (W + pop) * W;
`endif
    endfunction

    // Cycle 1 is the cycle right after the start edge.
    task automatic wait_done(input int cyc0, output int cyc);
        cyc = cyc0;
        while (!done && cyc < LIMIT) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        base_d = v.b;
        exp_d  = v.e;
        mod_d  = v.m;
        start  = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, lat);
        last_lat = lat;
        check({tag, " result"}, result, v.res);
        check({tag, " error"}, error, v.err);
        check({tag, " latency"}, lat, exp_lat(v.b, v.e, v.m));
        tick();
        check({tag, " done width/ready"}, {done, ready}, 2'b01);
    endtask

    vec_t vecs[16];

    initial begin
        int  cyc;
        logic saw_done;

        vecs[0]  = '{b: 16'd4,     e: 16'd13,    m: 16'd497,   res: 16'd445,   err: 1'b0};
        vecs[1]  = '{b: 16'd5,     e: 16'd0,     m: 16'd7,     res: 16'd1,     err: 1'b0};
        vecs[2]  = '{b: 16'd0,     e: 16'd9,     m: 16'd1,     res: 16'd0,     err: 1'b0};
        vecs[3]  = '{b: 16'd0,     e: 16'd5,     m: 16'd11,    res: 16'd0,     err: 1'b0};
        vecs[4]  = '{b: 16'd0,     e: 16'd0,     m: 16'd1,     res: 16'd0,     err: 1'b0};
        vecs[5]  = '{b: 16'd3,     e: 16'd4,     m: 16'd7,     res: 16'd4,     err: 1'b0};
        vecs[6]  = '{b: 16'd2,     e: 16'd10,    m: 16'd1000,  res: 16'd24,    err: 1'b0};
        vecs[7]  = '{b: 16'd65534, e: 16'd2,     m: 16'd65535, res: 16'd1,     err: 1'b0};
        vecs[8]  = '{b: 16'd65534, e: 16'd3,     m: 16'd65535, res: 16'd65534, err: 1'b0};
        vecs[9]  = '{b: 16'd12345, e: 16'd2,     m: 16'd65521, res: 16'd62700, err: 1'b0};
        vecs[10] = '{b: 16'd6,     e: 16'd1,     m: 16'd7,     res: 16'd6,     err: 1'b0};
        vecs[11] = '{b: 16'd9,     e: 16'd3,     m: 16'd7,     res: 16'd0,     err: 1'b1};
        vecs[12] = '{b: 16'd5,     e: 16'd3,     m: 16'd0,     res: 16'd0,     err: 1'b1};
        vecs[13] = '{b: 16'd7,     e: 16'd1,     m: 16'd7,     res: 16'd0,     err: 1'b1};
        vecs[14] = '{b: 16'd1,     e: 16'd65535, m: 16'd2,     res: 16'd1,     err: 1'b0};
        vecs[15] = '{b: 16'd65,    e: 16'd17,    m: 16'd3233,  res: 16'd2790,  err: 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        chain_en = 1'b0;
        base_d   = '0;
        exp_d    = '0;
        mod_d    = '0;
        repeat (2) tick();
        reset = 1'b0;
        check("reset state {ready,busy,done,error}", {ready, busy, done, error}, 4'b1000);
        check("reset result", result, 0);

        run_vec(vecs[0], "plan1");
`ifdef MOD_EXP_EARLY_EXIT_EN
        check("plan1 absolute latency", last_lat, 114);
`else
        check("plan1 absolute latency", last_lat, 306);
`endif

        for (int i = 1; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Error flag holds after done, then the next accepted request clears it.
        run_vec(vecs[11], "err hold");
        repeat (3) tick();
        check("error held in idle", {error, ready}, 2'b11);
        run_vec(vecs[6], "err clear");

        // Chained RSA round trip: first done starts the second engine on its result.
        check("chain engine idle", ready2, 1);
        chain_en = 1'b1;
        run_vec(vecs[15], "rsa enc");
        chain_en = 1'b0;
        cyc = 0;
        while (!done2 && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        check("rsa dec result", result2, 65);
        check("rsa dec error", error2, 0);
        check("rsa dec completed", done2, 1);

        // Start while busy is ignored; operand changes after capture have no effect.
        base_d = 16'd4;
        exp_d  = 16'd13;
        mod_d  = 16'd497;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        base_d = 16'd100;
        exp_d  = 16'd3;
        mod_d  = 16'd5;
        cyc = 1;
        repeat (5) begin
            tick();
            cyc++;
        end
        check("busy during compute", {busy, ready}, 2'b10);
        start = 1'b1;
        tick();
        cyc++;
        start = 1'b0;
        wait_done(cyc, cyc);
        check("ignored start result", result, 445);
        check("ignored start error", error, 0);
        check("ignored start latency", cyc, exp_lat(16'd4, 16'd13, 16'd497));
        tick();

        // Reset in the middle of SQR aborts without a done pulse.
        base_d = 16'd3;
        exp_d  = 16'd4;
        mod_d  = 16'd7;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("busy before reset", busy, 1);
        reset = 1'b1;
        tick();
        check("mid reset {ready,busy,done}", {ready, busy, done}, 3'b100);
        check("mid reset result", result, 0);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (600) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("no done after abort", saw_done, 0);
        run_vec(vecs[5], "after reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mod_exp_engine.md
Name: mod_exp_engine

Overview:
- Parametrised sequential modular-exponentiation core: result = base^exponent mod modulus.
- Successor to the fixed-width exponentiator used inside the RSA control path; operand width and exponent width are independent parameters.
- Adds a start/ready/done handshake, operand validity checking with an error flag, and an optional leading-zero skip.
- Instantiated twice by the RSA control path (encrypt and decrypt sides); also usable standalone.

Parameters:
- WIDTH, 128, bit width of base, modulus and result.
- EXP_WIDTH, 128, bit width of the exponent.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a computation; sampled only while ready=1.
- base  input  WIDTH  base operand; must be less than modulus.
- exponent  input  EXP_WIDTH  exponent operand.
- modulus  input  WIDTH  modulus; must be non-zero.
- ready  output  1  engine is idle and will accept start.
- busy  output  1  computation in progress.
- done  output  1  one-cycle pulse; result and error are valid.
- error  output  1  last request was rejected; valid while done=1, then held.
- result  output  WIDTH  last result; held until the next accepted start.

Behaviour:
- Reset (sampled on a clk edge) forces IDLE, ready=1, busy=0, done=0, error=0, result=0. Reset mid-operation aborts the computation with no done pulse.
- Operand capture:
  - Operands are registered on the edge where start=1 and ready=1.
  - After capture, input changes have no effect.
  - start is ignored while busy or in DONE.
- States: IDLE, CHECK, SQR, MUL, DONE.
- IDLE: ready=1. On an accepted start, go to CHECK.
- CHECK (1 cycle):
  - If modulus==0 or base>=modulus: error=1, result=0, go to DONE.
  - Otherwise: acc = (modulus==1) ? 0 : 1, bit index = EXP_WIDTH-1, go to SQR.
- SQR (WIDTH cycles): acc = acc*acc mod modulus.
  - On completion, if exponent[index]=1 go to MUL.
  - Otherwise, if index==0 go to DONE; else decrement index and stay in SQR.
- MUL (WIDTH cycles): acc = acc*base mod modulus. On completion, apply the same index-advance rule as SQR.
- Modular multiply is interleaved MSB-first over the multiplier, one bit per cycle:
  - t = 2*acc; subtract modulus if t >= modulus.
  - If the multiplier bit is set: t = t + multiplicand; subtract modulus if t >= modulus.
  - Intermediates are WIDTH+1 bits; no overflow is possible because both operands are less than modulus.
- DONE (1 cycle): done=1, result=acc (or 0 on error), then return to IDLE. result and error hold until the next accepted start, which clears error.
- busy=1 in CHECK, SQR and MUL; ready=1 only in IDLE.
- Latency without the optional feature: done is high in cycle 2 + (EXP_WIDTH + popcount(exponent))*WIDTH after the start edge. Error path: done in cycle 2.
- exponent==0: result = 1 mod modulus, i.e. 1, or 0 when modulus==1.
- start held high continuously re-triggers immediately on the IDLE cycle after DONE.

Optional Feature:
- Macro: MOD_EXP_EARLY_EXIT_EN.
- Defined:
  - CHECK sets the bit index to the position of the exponent's most significant set bit.
  - If exponent==0, CHECK goes directly to DONE with result = 1 mod modulus; done is in cycle 2.
  - Latency is 2 + (msb_index+1 + popcount)*WIDTH.
- Undefined: all EXP_WIDTH bits are processed, as specified above.
- Results are identical either way; only latency differs.

Test Plan:
1. WIDTH=16, EXP_WIDTH=16, base=4, exponent=13, modulus=497 -> result=445, error=0. done in cycle 306 (feature off) or cycle 114 (feature on).
2. RSA round trip, WIDTH=16: 65^17 mod 3233 -> result 2790; then 2790^2753 mod 3233 -> result 65. Two chained instances with done driving the second start.
3. Boundaries: base=5, exp=0, mod=7 -> result 1. base=0, exp=9, mod=1 -> result 0. base=0, exp=5, mod=11 -> result 0.
4. Errors: mod=0 -> error=1, result=0, done in cycle 2. base=9, mod=7 -> error=1. The next valid request clears error.
5. Handshake: a start pulse while busy is ignored and the result is unaffected. Operands changed after capture do not affect the result. done is exactly one cycle wide.
6. Reset asserted mid-SQR -> next cycle ready=1, busy=0, result=0, and no done pulse. A subsequent request completes correctly.
